// File: rtl/tdm_demux_4bit_1to4.sv
// ---------------------------------------------------------------------------
// tdm_demux_4bit_1to4
//
// Receive side of a 4-bit, 4-slot time-division multiplexed link. A single
// nibble stream carries one channel per valid beat. The frame boundary is
// marked by sof on the channel A beat. The block splits the stream into four
// registered 4-bit channels.
//
// Beats A, B and C are held in shadow registers while the frame is being
// collected. When the D beat arrives, all four channel outputs load together
// on the same edge: A, B and C come from the shadow registers and D comes
// straight from din. Because of this, downstream logic never sees a frame
// that is partly updated.
//
// Protocol violations abort the partial frame. Each one raises a one-cycle
// frame_err pulse and leaves the channel outputs untouched:
//   - a beat without sof while idle
//   - a sof in the middle of a frame (the frame restarts on this beat)
//   - a gap of TIMEOUT idle cycles inside a frame
// ---------------------------------------------------------------------------
module tdm_demux_4bit_1to4 #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       din_valid,
    input  logic       sof,
    output logic [3:0] ch_a,
    output logic [3:0] ch_b,
    output logic [3:0] ch_c,
    output logic [3:0] ch_d,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [1:0] slot,
    output logic       busy
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    // Keep the timeout inside the range the 8-bit idle counter can reach.
    // An out-of-range parameter then degrades gracefully instead of
    // producing a frame that can never time out.
    localparam int TIMEOUT_CLAMPED = (TIMEOUT < 1)   ? 1   :
                                     (TIMEOUT > 255) ? 255 : TIMEOUT;

    // Nine bits wide, so that idle_cnt + 1 cannot overflow in the compare.
    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CLAMPED);

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0] state;
    logic [7:0] idle_cnt;
    logic [3:0] shadow_a;
    logic [3:0] shadow_b;
    logic [3:0] shadow_c;

    // -----------------------------------------------------------------------
    // Next-state controls
    // -----------------------------------------------------------------------
    logic [0:0] state_nxt;
    logic [1:0] slot_nxt;
    logic [7:0] idle_cnt_nxt;
    logic       shadow_we;
    logic [1:0] shadow_sel;
    logic       load_ch;
    logic       frame_valid_nxt;
    logic       frame_err_nxt;
    logic       timeout_hit;

    // Becomes true on the gap cycle that would bring the idle count up to
    // TIMEOUT.
    assign timeout_hit = ({1'b0, idle_cnt} + 9'd1) >= TIMEOUT_LIM;

    // -----------------------------------------------------------------------
    // Frame-tracking FSM: decode the current beat into the register updates
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // forgets an assignment then holds the default, and no latch is
        // inferred.
        state_nxt       = state;
        slot_nxt        = slot;
        idle_cnt_nxt    = idle_cnt;
        shadow_we       = 1'b0;
        shadow_sel      = SLOT_A;
        load_ch         = 1'b0;
        frame_valid_nxt = 1'b0;
        frame_err_nxt   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (din_valid) begin
                    if (sof) begin
                        // Channel A beat opens a new frame.
                        shadow_we    = 1'b1;
                        shadow_sel   = SLOT_A;
                        slot_nxt     = SLOT_B;
                        idle_cnt_nxt = 8'd0;
                        state_nxt    = ST_COLLECT;
                    end else begin
                        // Stray beat with no frame open: drop it and flag it.
                        frame_err_nxt = 1'b1;
                        slot_nxt      = SLOT_A;
                    end
                end
            end

            ST_COLLECT: begin
                if (din_valid) begin
                    idle_cnt_nxt = 8'd0;
                    if (sof) begin
                        // Early sof: drop the partial frame and restart on
                        // this beat. Slots B and C are rewritten before the
                        // next load, so stale shadow data can never leak out.
                        frame_err_nxt = 1'b1;
                        shadow_we     = 1'b1;
                        shadow_sel    = SLOT_A;
                        slot_nxt      = SLOT_B;
                    end else if (slot == SLOT_D) begin
                        // Last beat: publish the whole frame at once.
                        load_ch         = 1'b1;
                        frame_valid_nxt = 1'b1;
                        slot_nxt        = SLOT_A;
                        state_nxt       = ST_IDLE;
                    end else begin
                        shadow_we  = 1'b1;
                        shadow_sel = slot;
                        slot_nxt   = slot + 2'd1;
                    end
                end else if (timeout_hit) begin
                    // The link went quiet mid-frame: give up on it.
                    frame_err_nxt = 1'b1;
                    idle_cnt_nxt  = 8'd0;
                    slot_nxt      = SLOT_A;
                    state_nxt     = ST_IDLE;
                end else begin
                    idle_cnt_nxt = idle_cnt + 8'd1;
                end
            end

            default: begin
                // Unreachable with a 1-bit state. Kept so that any corruption
                // recovers to a clean idle.
                state_nxt    = ST_IDLE;
                slot_nxt     = SLOT_A;
                idle_cnt_nxt = 8'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers: FSM state, slot pointer, idle counter, pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            slot        <= SLOT_A;
            idle_cnt    <= 8'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // register then samples the pre-edge values, whatever order the
            // statements are written in.
            state       <= state_nxt;
            slot        <= slot_nxt;
            idle_cnt    <= idle_cnt_nxt;
            frame_valid <= frame_valid_nxt;
            frame_err   <= frame_err_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Shadow registers: hold beats A..C until the frame completes
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this small storage is reset on purpose, so that it has a
            // known value after reset. Wide data memories normally go
            // without reset.
            shadow_a <= 4'h0;
            shadow_b <= 4'h0;
            shadow_c <= 4'h0;
        end else if (shadow_we) begin
            case (shadow_sel)
                SLOT_A:  shadow_a <= din;
                SLOT_B:  shadow_b <= din;
                SLOT_C:  shadow_c <= din;
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Channel outputs: change only when a complete frame is accepted
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_a <= 4'h0;
            ch_b <= 4'h0;
            ch_c <= 4'h0;
            ch_d <= 4'h0;
        end else if (load_ch) begin
            ch_a <= shadow_a;
            ch_b <= shadow_b;
            ch_c <= shadow_c;
            ch_d <= din;
        end
    end

    assign busy = (state == ST_COLLECT);

endmodule

// File: tb/tb_tdm_demux_4bit_1to4.sv
// ---------------------------------------------------------------------------
// Directed bench for tdm_demux_4bit_1to4. Uses TIMEOUT=3 so that the
// gap-abort case stays short. Each step drives one cycle of input just after
// a rising edge and checks the registered outputs 1 ns after the next edge.
// ---------------------------------------------------------------------------
module tb_tdm_demux_4bit_1to4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'h0;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic [3:0] ch_a;
    logic [3:0] ch_b;
    logic [3:0] ch_c;
    logic [3:0] ch_d;
    logic       frame_valid;
    logic       frame_err;
    logic [1:0] slot;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    tdm_demux_4bit_1to4 #(.TIMEOUT(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .ch_a        (ch_a),
        .ch_b        (ch_b),
        .ch_c        (ch_c),
        .ch_d        (ch_d),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .slot        (slot),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; returns 1 ns after the edge that sampled it
    task automatic step(input logic v, input logic s, input logic [3:0] d);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    // Checks the status outputs, packed as {fv, err, busy, slot}
    task automatic status(input string tag, input logic fv, input logic err,
                          input logic bsy, input logic [1:0] sl);
        check(tag, {11'd0, frame_valid, frame_err, busy, slot},
                   {11'd0, fv, err, bsy, sl});
    endtask

    task automatic chans(input string tag, input logic [15:0] exp);
        check(tag, {ch_a, ch_b, ch_c, ch_d}, exp);
    endtask

    initial begin
        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        chans("reset_ch", 16'h0000);
        status("reset_status", 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;

        // ---- single frame 1,2,3,4
        step(1'b1, 1'b1, 4'h1);
        status("f1_a", 1'b0, 1'b0, 1'b1, 2'd1);
        step(1'b1, 1'b0, 4'h2);
        status("f1_b", 1'b0, 1'b0, 1'b1, 2'd2);
        step(1'b1, 1'b0, 4'h3);
        status("f1_c", 1'b0, 1'b0, 1'b1, 2'd3);
        chans("f1_ch_hold", 16'h0000);
        step(1'b1, 1'b0, 4'h4);
        status("f1_done", 1'b1, 1'b0, 1'b0, 2'd0);
        chans("f1_ch", 16'h1234);
        step(1'b0, 1'b0, 4'h0);
        status("f1_pulse_end", 1'b0, 1'b0, 1'b0, 2'd0);

        // ---- back-to-back frames A..D then 5..8, pulses 4 cycles apart
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b0, 4'hB);
        step(1'b1, 1'b0, 4'hC);
        step(1'b1, 1'b0, 4'hD);
        status("b2b_1_done", 1'b1, 1'b0, 1'b0, 2'd0);
        chans("b2b_1_ch", 16'hABCD);
        step(1'b1, 1'b1, 4'h5);
        status("b2b_2_a", 1'b0, 1'b0, 1'b1, 2'd1);
        step(1'b1, 1'b0, 4'h6);
        step(1'b1, 1'b0, 4'h7);
        status("b2b_2_c", 1'b0, 1'b0, 1'b1, 2'd3);
        chans("b2b_2_hold", 16'hABCD);
        step(1'b1, 1'b0, 4'h8);
        status("b2b_2_done", 1'b1, 1'b0, 1'b0, 2'd0);
        chans("b2b_2_ch", 16'h5678);
        step(1'b0, 1'b0, 4'h0);
        status("b2b_idle", 1'b0, 1'b0, 1'b0, 2'd0);

        // ---- early sof restart: 9(sof), A, B(sof), C, D, E
        step(1'b1, 1'b1, 4'h9);
        step(1'b1, 1'b0, 4'hA);
        status("rs_partial", 1'b0, 1'b0, 1'b1, 2'd2);
        step(1'b1, 1'b1, 4'hB);
        status("rs_err", 1'b0, 1'b1, 1'b1, 2'd1);
        chans("rs_hold", 16'h5678);
        step(1'b1, 1'b0, 4'hC);
        status("rs_err_end", 1'b0, 1'b0, 1'b1, 2'd2);
        step(1'b1, 1'b0, 4'hD);
        step(1'b1, 1'b0, 4'hE);
        status("rs_done", 1'b1, 1'b0, 1'b0, 2'd0);
        chans("rs_ch", 16'hBCDE);

        // ---- timeout: sof beat then 3 idle cycles (one idle cycle has sof
        //      high with din_valid low, which must be ignored)
        step(1'b1, 1'b1, 4'hF);
        status("to_start", 1'b0, 1'b0, 1'b1, 2'd1);
        step(1'b0, 1'b0, 4'h0);
        status("to_gap1", 1'b0, 1'b0, 1'b1, 2'd1);
        step(1'b0, 1'b1, 4'h3);
        status("to_gap2", 1'b0, 1'b0, 1'b1, 2'd1);
        step(1'b0, 1'b0, 4'h0);
        status("to_abort", 1'b0, 1'b1, 1'b0, 2'd0);
        chans("to_ch", 16'hBCDE);
        step(1'b0, 1'b0, 4'h0);
        status("to_err_end", 1'b0, 1'b0, 1'b0, 2'd0);

        // ---- stray beat while idle
        step(1'b1, 1'b0, 4'h7);
        status("stray_err", 1'b0, 1'b1, 1'b0, 2'd0);
        chans("stray_ch", 16'hBCDE);
        step(1'b0, 1'b0, 4'h0);
        status("stray_err_end", 1'b0, 1'b0, 1'b0, 2'd0);

        // ---- reset mid-frame after 2 beats, then a clean frame
        step(1'b1, 1'b1, 4'h3);
        step(1'b1, 1'b0, 4'h4);
        status("mid_partial", 1'b0, 1'b0, 1'b1, 2'd2);
        din_valid = 1'b0;
        sof       = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chans("mid_rst_ch", 16'h0000);
        status("mid_rst_status", 1'b0, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        status("mid_rst_hold", 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        step(1'b1, 1'b1, 4'h6);
        status("post_a", 1'b0, 1'b0, 1'b1, 2'd1);
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h8);
        step(1'b1, 1'b0, 4'h9);
        status("post_done", 1'b1, 1'b0, 1'b0, 2'd0);
        chans("post_ch", 16'h6789);
        step(1'b0, 1'b0, 4'h0);
        status("post_end", 1'b0, 1'b0, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tdm_demux_4bit_1to4.md
TDM_DEMUX_4BIT_1TO4 -- requirements
Module: tdm_demux_4bit_1to4

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum consecutive cycles without din_valid inside a frame before the frame is aborted (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 din  input  4  serial nibble stream, one channel per beat.
REQ-005 din_valid  input  1  din carries a beat this cycle.
REQ-006 sof  input  1  start of frame; qualified by din_valid; marks the channel A beat.
REQ-007 ch_a, ch_b, ch_c, ch_d  output  4 each  registered channel outputs from the last complete frame.
REQ-008 frame_valid  output  1  one-cycle pulse when ch_a..ch_d update.
REQ-009 frame_err  output  1  one-cycle pulse on any protocol violation.
REQ-010 slot  output  2  index of the next expected beat (0=A, 1=B, 2=C, 3=D).
REQ-011 busy  output  1  high while in COLLECT.

Function
REQ-012 The block is the receive-side inverse of the 4-bit 4:1 mux: one 4-bit stream is demultiplexed into four 4-bit channels by time slot, not by an external select.
REQ-013 FSM states: IDLE and COLLECT only; busy = (state == COLLECT).
REQ-014 IDLE, din_valid && sof: store din in shadow slot 0, set slot=1, clear the idle counter, go to COLLECT.
REQ-015 IDLE, din_valid && !sof: discard the beat, pulse frame_err next cycle, stay in IDLE with slot=0.
REQ-016 COLLECT, din_valid && !sof: store din in shadow[slot], then slot increments, wrapping 3 -> 0; clear the idle counter.
REQ-017 When the slot-3 beat is accepted: on the same edge, ch_a..ch_d load shadow A, B, C and din simultaneously; frame_valid is high for exactly the following cycle; state returns to IDLE and slot=0.
REQ-018 COLLECT, din_valid && sof: pulse frame_err, discard the partial frame, and treat this beat as the slot-0 beat of a new frame (slot=1, stay in COLLECT).
REQ-019 COLLECT, !din_valid: the idle counter increments; when it reaches TIMEOUT, pulse frame_err, discard the partial frame, go to IDLE with slot=0.
REQ-020 sof is ignored when din_valid=0.
REQ-021 ch_a..ch_d change only per REQ-017; aborted or partial frames never alter them.
REQ-022 frame_valid and frame_err are registered and never high for more than one consecutive cycle per event; a restart per REQ-018 does not assert frame_valid.
REQ-023 Latency: frame_valid rises 1 cycle after the edge that samples the slot-3 beat; back-to-back frames at 1 beat/cycle are sustained (throughput 4 cycles/frame).

Reset
REQ-024 While rst=1: state=IDLE, slot=0, idle counter=0, shadow=0, ch_a..ch_d=4'h0, frame_valid=0, frame_err=0, busy=0.
REQ-025 Reset asserted mid-frame aborts the frame with no frame_err or frame_valid pulse; the first beat after deassertion is handled per REQ-014/015.

Verification
REQ-026 Beats 4'h1(sof), 4'h2, 4'h3, 4'h4 on consecutive cycles -> ch_a..ch_d = 1,2,3,4; single frame_valid pulse; frame_err never set.
REQ-027 Two back-to-back frames with no gap (A..D then 5..8) -> two frame_valid pulses 4 cycles apart; final outputs 5,6,7,8.
REQ-028 sof beat 4'h9 then 4'hA, then sof beat 4'hB followed by C, D, E -> one frame_err pulse; outputs B,C,D,E; the aborted frame never appears on the outputs.
REQ-029 TIMEOUT=3: sof beat then a 3-cycle gap -> frame_err pulse, busy falls, slot=0, outputs unchanged.
REQ-030 din_valid without sof while in IDLE -> frame_err pulse, outputs and slot unchanged.
REQ-031 rst asserted after 2 beats of a frame -> all outputs 0 immediately, no pulses; a subsequent clean frame completes normally.
